// File: rtl/truth_probe.sv
// ---------------------------------------------------------------------------
// truth_probe
//
// Walks a 3-input combinational unit through all 8 input vectors. For each
// vector it spends one cycle driving the stimulus (DRIVE) and one cycle
// letting it settle (SAMPLE), then captures the response h on the SAMPLE exit
// edge. After the 8th capture it compares the captured table against a
// golden truth table that was latched when the run started.
//
// Ports
//   clk             rising-edge clock for all state
//   reset           synchronous active-high reset
//   start           begin a new run; honoured only in IDLE
//   expected[7:0]   golden table, bit k = expected response for vector k
//   h               combinational response of the unit under probe
//   n, j, s         registered stimulus (n = idx[2], j = idx[1], s = idx[0])
//   busy            high while the run is in DRIVE or SAMPLE
//   done            one-cycle pulse when a run completes
//   resp_table[7:0] captured responses, bit k = h for vector k
//                   (named resp_table because `table` is a reserved word)
//   match           resp_table equals the latched golden table
//   mismatch_count  number of differing bits between the two tables (0-8)
// ---------------------------------------------------------------------------
module truth_probe (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       h,
    output logic       n,
    output logic       j,
    output logic       s,
    output logic       busy,
    output logic       done,
    output logic [7:0] resp_table,
    output logic       match,
    output logic [3:0] mismatch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] exp_q;
    logic [7:0] table_nx;
    logic [3:0] diff_cnt;
    logic       run_start;
    logic       run_last;

    // Next-state and next-datapath logic.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        table_nx  = resp_table;
        run_start = 1'b0;
        run_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = DRIVE;
                    idx_nx    = 3'd0;
                    table_nx  = 8'h00;
                    run_start = 1'b1;
                end
            end
            DRIVE: state_nx = SAMPLE;
            SAMPLE: begin
                // h is captured only here, so toggles in any other state are
                // invisible to the table.
                table_nx[idx] = h;
                if (idx == 3'd7) begin
                    state_nx = DONE;
                    run_last = 1'b1;
                end else begin
                    state_nx = DRIVE;
                    idx_nx   = idx + 3'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Popcount of the final table against the golden copy. Uses table_nx so
    // the 8th capture is included on the edge that enters DONE.
    always_comb begin
        diff_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            diff_cnt = diff_cnt + {3'd0, table_nx[i] ^ exp_q[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and registered outputs. Outputs are loaded from the next-state
    // decode so they line up with the state they describe.
    // NOTE: the captured table and golden copy are plain flops, not a memory
    // array, so they are cleared by reset like any other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx            <= 3'd0;
            exp_q          <= 8'h00;
            resp_table     <= 8'h00;
            match          <= 1'b0;
            mismatch_count <= 4'd0;
            {n, j, s}      <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            idx        <= idx_nx;
            resp_table <= table_nx;
            busy       <= (state_nx == DRIVE) || (state_nx == SAMPLE);
            done       <= (state_nx == DONE);
            {n, j, s}  <= ((state_nx == DRIVE) || (state_nx == SAMPLE)) ? idx_nx : 3'd0;
            if (run_start) begin
                // Golden table is frozen here; later changes to expected do
                // not affect this run's result.
                exp_q          <= expected;
                match          <= 1'b0;
                mismatch_count <= 4'd0;
            end else if (run_last) begin
                match          <= (table_nx == exp_q);
                mismatch_count <= diff_cnt;
            end
        end
    end

endmodule

// File: tb/tb_truth_probe.sv
// ---------------------------------------------------------------------------
// tb_truth_probe
//
// Self-checking bench for truth_probe. A table of directed runs (golden
// table, response mode, mid-run disturbances, expected results) is applied in
// a loop; hand-written sequences cover reset, start held high and reset in
// the middle of a run. Inputs change and outputs are read on the falling edge.
//
// Response modes for h:
//   0  h = n & (s | j)        (reference unit)
//   1  h = 1
//   2  h = 0
//   3  h = 1 during DRIVE cycles, 0 during SAMPLE cycles (bench-driven)
// ---------------------------------------------------------------------------
module tb_truth_probe;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] expected;
    logic       h;
    logic       n, j, s;
    logic       busy, done;
    logic [7:0] resp_table;
    logic       match;
    logic [3:0] mismatch_count;

    logic [1:0] mode;
    logic       tb_h;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign h = (mode == 2'd0) ? (n & (s | j)) :
               (mode == 2'd1) ? 1'b1 :
               (mode == 2'd2) ? 1'b0 : tb_h;

    truth_probe dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .expected       (expected),
        .h              (h),
        .n              (n),
        .j              (j),
        .s              (s),
        .busy           (busy),
        .done           (done),
        .resp_table     (resp_table),
        .match          (match),
        .mismatch_count (mismatch_count)
    );

    typedef struct {
        logic [7:0] exp_in;
        logic [1:0] hmode;
        int         chg_at;      // cycle to change expected (-1 = never)
        logic [7:0] chg_val;
        int         start_at;    // cycle to raise start mid-run (-1 = never)
        logic [7:0] want_table;
        logic       want_match;
        logic [3:0] want_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endtask

    // Called just after a falling edge. Starts a run, walks it to completion
    // and checks stimulus, latency, busy span, results and hold behaviour.
    task automatic run_check(input string name, input vec_t v);
        int cyc;
        int busy_cnt;
        int stim_bad;
        logic got_done;
        expected = v.exp_in;
        mode     = v.hmode;
        tb_h     = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, " clr"}, {resp_table, match, mismatch_count}, 13'd0);
        cyc = 0; busy_cnt = 0; stim_bad = 0; got_done = 1'b0;
        while (cyc < 40) begin
            tb_h = (cyc % 2 == 0);
            if (cyc == v.chg_at) expected = v.chg_val;
            start = (cyc == v.start_at);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (cyc < 16 && {n, j, s} != 3'(cyc / 2)) stim_bad++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, " done seen"}, 32'(got_done), 32'd1);
        check({name, " latency"}, cyc, 16);
        check({name, " busy cycles"}, busy_cnt, 16);
        check({name, " stimulus walk"}, stim_bad, 0);
        check({name, " table"}, resp_table, v.want_table);
        check({name, " match"}, match, v.want_match);
        check({name, " mismatch_count"}, mismatch_count, v.want_cnt);
        check({name, " njs idle in done"}, {n, j, s, busy}, 4'd0);
        @(negedge clk);
        check({name, " after done"}, {done, busy, n, j, s}, 5'd0);
        check({name, " held"}, {resp_table, match, mismatch_count},
              {v.want_table, v.want_match, v.want_cnt});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_cnt, d1, d2;
        logic b17, b18;
        vec_t rv;

        vecs[0] = '{8'hE0, 2'd0, -1, 8'h00, -1, 8'hE0, 1'b1, 4'd0};
        vecs[1] = '{8'h1F, 2'd0, -1, 8'h00, -1, 8'hE0, 1'b0, 4'd8};
        vecs[2] = '{8'hFF, 2'd1, -1, 8'h00, -1, 8'hFF, 1'b1, 4'd0};
        vecs[3] = '{8'h00, 2'd2, -1, 8'h00, -1, 8'h00, 1'b1, 4'd0};
        vecs[4] = '{8'h00, 2'd3, -1, 8'h00, -1, 8'h00, 1'b1, 4'd0};
        vecs[5] = '{8'hE1, 2'd0, -1, 8'h00, -1, 8'hE0, 1'b0, 4'd1};
        vecs[6] = '{8'h0F, 2'd1, -1, 8'h00, -1, 8'hFF, 1'b0, 4'd4};
        vecs[7] = '{8'hE0, 2'd0,  4, 8'h00, -1, 8'hE0, 1'b1, 4'd0};
        vecs[8] = '{8'hE0, 2'd0, -1, 8'h00,  5, 8'hE0, 1'b1, 4'd0};
        vecs[9] = '{8'h1F, 2'd0, -1, 8'h00, 16, 8'hE0, 1'b0, 4'd8};

        reset = 1'b1; start = 1'b1; expected = 8'hAA; mode = 2'd1; tb_h = 1'b0;
        repeat (2) @(negedge clk);
        check("reset state",
              {n, j, s, busy, done, resp_table, match, mismatch_count}, 17'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle after reset", {busy, done}, 2'd0);

        for (int k = 0; k < 10; k++) begin
            run_check($sformatf("vec%0d", k), vecs[k]);
        end

        // start held high: one run, then a second accepted on the first IDLE edge.
        expected = 8'hFF; mode = 2'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_cnt = 0; d1 = -1; d2 = -1; b17 = 1'b1; b18 = 1'b0;
        for (int c = 0; c < 38; c++) begin
            if (c == 20) start = 1'b0;
            if (done) begin
                d_cnt++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c == 17) b17 = busy;
            if (c == 18) b18 = busy;
            @(negedge clk);
        end
        check("held start done pulses", d_cnt, 2);
        check("held start first done", d1, 16);
        check("held start second done", d2, 34);
        check("held start idle gap", b17, 1'b0);
        check("held start rerun busy", b18, 1'b1);
        check("held start table", resp_table, 8'hFF);
        check("held start match", match, 1'b1);

        // Reset during SAMPLE of vector 3 abandons the run.
        expected = 8'hFF; mode = 2'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid-run njs before reset", {n, j, s, busy}, 4'b0111);
        reset = 1'b1;
        @(negedge clk);
        check("mid-run reset outputs",
              {n, j, s, busy, done, resp_table, match, mismatch_count}, 17'd0);
        reset = 1'b0;
        rv = '{8'hE0, 2'd0, -1, 8'h00, -1, 8'hE0, 1'b1, 4'd0};
        run_check("after reset", rv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
